// File: rtl/control_sequencer.sv
// Hardwired control unit for the 8-bit CPU: two-byte fetch, decode, and
// execute sequencing for NOP/MOV/MVI/HLT, driving Moore control strobes.
module control_sequencer #(
  parameter int ID_W  = 4,
  parameter int ALU_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       ir0,
  input  logic [7:0]       ir1,
  output logic [14:0]      oe,
  output logic [12:0]      we,
  output logic             oe_pc,
  output logic             oe_ar,
  output logic             pc_inr,
  output logic [ALU_W-1:0] alu_opcode,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC, S_EX0, S_EX1, S_HALT
  } state_t;

  localparam logic [1:0]  OP_NOP = 2'b00;
  localparam logic [1:0]  OP_MOV = 2'b01;
  localparam logic [1:0]  OP_MVI = 2'b10;
  localparam logic [1:0]  OP_HLT = 2'b11;
  localparam logic [14:0] OE_M   = 15'h0010;
  localparam logic [ID_W-1:0] ID_M = ID_W'(4);

  state_t           r_state;
  state_t           w_next;
  state_t           w_boundary;
  logic [1:0]       r_op;
  logic [ID_W-1:0]  r_src;
  logic [ID_W-1:0]  r_dst;
  logic [ALU_W-1:0] r_alu;
  logic             r_illegal;

  logic [1:0]       w_op;
  logic [ID_W-1:0]  w_src;
  logic [ID_W-1:0]  w_dst;
  logic             w_reject;

  function automatic logic dst_ok(input logic [ID_W-1:0] d);
    return (d >= ID_W'(2)) && (d <= ID_W'(12));
  endfunction

  function automatic logic mov_ok(input logic [ID_W-1:0] s, input logic [ID_W-1:0] d);
    return (s <= ID_W'(14)) && dst_ok(d) && (s != d);
  endfunction

  assign w_op  = ir0[7:6];
  assign w_src = ir1[7:4];
  assign w_dst = ir1[3:0];

  always_comb begin
    w_reject = 1'b0;
    if (w_op == OP_MOV)      w_reject = !mov_ok(w_src, w_dst);
    else if (w_op == OP_MVI) w_reject = !dst_ok(w_dst);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == S_DEC) && w_reject;
    end
  end

  // Decode fields latched at the end of DEC; execute states use only these
  always_ff @(posedge clk) begin
    if (r_state == S_DEC) begin
      r_op  <= w_op;
      r_src <= w_src;
      r_dst <= w_dst;
      r_alu <= ir0[ALU_W-1:0];
    end
  end

  always_comb begin
    w_boundary = run ? S_F0 : S_IDLE;
    w_next     = r_state;
    case (r_state)
      S_IDLE: if (run) w_next = S_F0;
      S_F0:   w_next = S_F1;
      S_F1:   w_next = S_F2;
      S_F2:   w_next = S_F3;
      S_F3:   w_next = S_DEC;
      S_DEC: begin
        case (w_op)
          OP_NOP:  w_next = w_boundary;
          OP_HLT:  w_next = S_HALT;
          default: w_next = w_reject ? w_boundary : S_EX0;
        endcase
      end
      S_EX0:  w_next = (r_op == OP_MVI) ? S_EX1 : w_boundary;
      S_EX1:  w_next = w_boundary;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oe         = '0;
    we         = '0;
    oe_pc      = 1'b0;
    oe_ar      = 1'b0;
    pc_inr     = 1'b0;
    alu_opcode = '0;
    halted     = 1'b0;
    case (r_state)
      S_F0, S_F2: begin
        oe_pc = 1'b1;
        oe    = OE_M;
      end
      S_F1: begin
        oe_pc  = 1'b1;
        oe     = OE_M;
        we     = 13'h0001;
        pc_inr = 1'b1;
      end
      S_F3: begin
        oe_pc  = 1'b1;
        oe     = OE_M;
        we     = 13'h0002;
        pc_inr = 1'b1;
      end
      S_EX0: begin
        if (r_op == OP_MOV) begin
          oe         = 15'(1) << r_src;
          we         = 13'(1) << r_dst;
          alu_opcode = r_alu;
          oe_ar      = (r_src == ID_M) || (r_dst == ID_M);
        end else begin
          oe_pc = 1'b1;
          oe    = OE_M;
        end
      end
      S_EX1: begin
        oe_pc  = 1'b1;
        oe     = OE_M;
        we     = 13'(1) << r_dst;
        pc_inr = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = r_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer: whole-output bundles
// compared cycle by cycle against hand-computed expectations.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  ir0;
  logic [7:0]  ir1;
  logic [14:0] oe;
  logic [12:0] we;
  logic        oe_pc;
  logic        oe_ar;
  logic        pc_inr;
  logic [4:0]  alu_opcode;
  logic        halted;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  logic prev_ill;

  control_sequencer #(.ID_W(4), .ALU_W(5)) dut (
    .clk(clk), .reset(reset), .run(run), .ir0(ir0), .ir1(ir1),
    .oe(oe), .we(we), .oe_pc(oe_pc), .oe_ar(oe_ar), .pc_inr(pc_inr),
    .alu_opcode(alu_opcode), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  i0;
    logic [7:0]  i1;
    int          len;
    logic [37:0] ex0;
    logic [37:0] ex1;
    logic        ill;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [37:0] mk(input logic [14:0] o, input logic [12:0] w,
                                     input logic opc, input logic oar, input logic inr,
                                     input logic [4:0] alu, input logic h, input logic il);
    return {o, w, opc, oar, inr, alu, h, il};
  endfunction

  function automatic logic [37:0] fetch_exp(input int t, input logic il);
    case (t)
      0:       return mk(15'h0010, 13'h0000, 1, 0, 0, 5'd0, 0, il);
      1:       return mk(15'h0010, 13'h0001, 1, 0, 1, 5'd0, 0, 0);
      2:       return mk(15'h0010, 13'h0000, 1, 0, 0, 5'd0, 0, 0);
      3:       return mk(15'h0010, 13'h0002, 1, 0, 1, 5'd0, 0, 0);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [37:0] exp);
    logic [37:0] act;
    act = {oe, we, oe_pc, oe_ar, pc_inr, alu_opcode, halted, illegal};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (oe,we,oe_pc,oe_ar,pc_inr,alu,halted,illegal)",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // First edge enters F0; one check per cycle up to the last instruction cycle
  task automatic run_instr(input vec_t v, input int idx, input logic drop_run);
    for (int t = 0; t < v.len; t++) begin
      tick();
      if (t < 5)       check($sformatf("v%0d_c%0d", idx, t), fetch_exp(t, prev_ill));
      else if (t == 5) check($sformatf("v%0d_ex0", idx), v.ex0);
      else             check($sformatf("v%0d_ex1", idx), v.ex1);
      if (t == 0) begin
        ir0 = v.i0;
        ir1 = v.i1;
        if (drop_run) run = 1'b0;
      end
      if (t == 5) begin
        ir0 = 8'hFF;
        ir1 = 8'hFF;
      end
    end
    prev_ill = v.ill;
  endtask

  initial begin
    vec_t hlt;
    vec_t nop;
    vec_t bad;

    tbl[0]  = '{8'h00, 8'h00, 5, '0, '0, 1'b0};
    tbl[1]  = '{8'h40, 8'h23, 6, mk(15'h0004, 13'h0008, 0, 0, 0, 5'd0, 0, 0), '0, 1'b0};
    tbl[2]  = '{8'h45, 8'hE5, 6, mk(15'h4000, 13'h0020, 0, 0, 0, 5'd5, 0, 0), '0, 1'b0};
    tbl[3]  = '{8'h40, 8'h42, 6, mk(15'h0010, 13'h0004, 0, 1, 0, 5'd0, 0, 0), '0, 1'b0};
    tbl[4]  = '{8'h40, 8'h24, 6, mk(15'h0004, 13'h0010, 0, 1, 0, 5'd0, 0, 0), '0, 1'b0};
    tbl[5]  = '{8'h80, 8'h06, 7, mk(15'h0010, 13'h0000, 1, 0, 0, 5'd0, 0, 0),
                                 mk(15'h0010, 13'h0040, 1, 0, 1, 5'd0, 0, 0), 1'b0};
    tbl[6]  = '{8'h40, 8'h33, 5, '0, '0, 1'b1};
    tbl[7]  = '{8'h40, 8'h21, 5, '0, '0, 1'b1};
    tbl[8]  = '{8'h40, 8'hF2, 5, '0, '0, 1'b1};
    tbl[9]  = '{8'h40, 8'h2D, 5, '0, '0, 1'b1};
    tbl[10] = '{8'h80, 8'h01, 5, '0, '0, 1'b1};
    tbl[11] = '{8'h80, 8'h0D, 5, '0, '0, 1'b1};
    tbl[12] = '{8'h80, 8'h0C, 7, mk(15'h0010, 13'h0000, 1, 0, 0, 5'd0, 0, 0),
                                 mk(15'h0010, 13'h1000, 1, 0, 1, 5'd0, 0, 0), 1'b0};
    tbl[13] = '{8'h5F, 8'h3C, 6, mk(15'h0008, 13'h1000, 0, 0, 0, 5'h1F, 0, 0), '0, 1'b0};
    tbl[14] = '{8'h3F, 8'hAB, 5, '0, '0, 1'b0};
    hlt = '{8'hC0, 8'h00, 5, '0, '0, 1'b0};
    nop = '{8'h00, 8'h00, 5, '0, '0, 1'b0};
    bad = '{8'h40, 8'h33, 5, '0, '0, 1'b1};

    reset = 1'b0;
    run   = 1'b0;
    ir0   = 8'h00;
    ir1   = 8'h00;
    prev_ill = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("reset_%0d", i), '0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_%0d", i), '0);
    end

    run = 1'b1;
    for (int i = 0; i < 15; i++) run_instr(tbl[i], i, 1'b0);

    run_instr(hlt, 100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("halt_%0d", i), mk('0, '0, 0, 0, 0, 5'd0, 1, 0));
    end

    reset = 1'b0;
    tick();
    check("halt_reset", '0);
    reset = 1'b1;
    run   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("post_halt_idle_%0d", i), '0);
    end

    run = 1'b1;
    tick();
    check("mf_f0", fetch_exp(0, 1'b0));
    tick();
    check("mf_f1", fetch_exp(1, 1'b0));
    reset = 1'b0;
    tick();
    check("mf_reset", '0);
    reset = 1'b1;
    prev_ill = 1'b0;
    run_instr(nop, 200, 1'b0);

    run_instr(bad, 300, 1'b1);
    tick();
    check("drop_run_idle_ill", mk('0, '0, 0, 0, 0, 5'd0, 0, 1));
    tick();
    check("drop_run_idle", '0);
    tick();
    check("drop_run_idle2", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
